// File: rtl/morse_encoder_if.sv
// Symbol handshake between the character-to-symbol sequencer (master) and
// the Morse transmitter (slave).
interface morse_encoder_if;
   logic [1:0] sym;
   logic       sym_valid;
   logic       sym_ready;

   modport master (output sym, output sym_valid, input sym_ready);
   modport slave  (input sym, input sym_valid, output sym_ready);
endinterface

// File: rtl/morse_encoder.sv
// Morse transmitter: takes one symbol per handshake and keys the output for a
// whole number of units, each unit being UNIT_TICKS clock cycles.
module morse_encoder #(
   parameter int unsigned UNIT_TICKS = 5_000_000
) (
   input  logic           clk,
   input  logic           reset,
   morse_encoder_if.slave up,
   output logic           key,
   output logic           busy,
   output logic           sym_done
);
   localparam int PW = (UNIT_TICKS > 1) ? $clog2(UNIT_TICKS) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(UNIT_TICKS - 1);

   typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

   state_t        state;
   logic [PW-1:0] presc;
   logic [2:0]    units;
   logic [2:0]    space_units;
   logic          unit_end;

   // Symbol codes: 00 dot, 01 dash, 10 letter gap, 11 word gap.
   function automatic logic [2:0] mark_of(input logic [1:0] code);
      case (code)
         2'b00:   return 3'd1;
         2'b01:   return 3'd3;
         default: return 3'd0;
      endcase
   endfunction

   function automatic logic [2:0] space_of(input logic [1:0] code);
      case (code)
         2'b10:   return 3'd2;
         2'b11:   return 3'd6;
         default: return 3'd1;
      endcase
   endfunction

   assign unit_end     = (presc == PRESC_MAX);
   assign up.sym_ready = (state == IDLE) && !reset;
   assign sym_done     = (state == SPACE) && (units == 3'd1) && unit_end;

   // NOTE: every register here uses <= so all state updates see the values from
   // before the edge; mixing in = would make the result depend on statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         presc       <= '0;
         units       <= '0;
         space_units <= '0;
         key         <= 1'b0;
         busy        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (up.sym_valid) begin
                  presc       <= '0;
                  busy        <= 1'b1;
                  space_units <= space_of(up.sym);
                  if (mark_of(up.sym) != 3'd0) begin
                     state <= MARK;
                     units <= mark_of(up.sym);
                     key   <= 1'b1;
                  end else begin
                     state <= SPACE;
                     units <= space_of(up.sym);
                  end
               end
            end
            MARK: begin
               if (unit_end) begin
                  presc <= '0;
                  if (units == 3'd1) begin
                     state <= SPACE;
                     units <= space_units;
                     key   <= 1'b0;
                  end else begin
                     units <= units - 3'd1;
                  end
               end else begin
                  presc <= presc + PW'(1);
               end
            end
            SPACE: begin
               if (unit_end) begin
                  presc <= '0;
                  if (units == 3'd1) begin
                     state <= IDLE;
                     units <= '0;
                     busy  <= 1'b0;
                  end else begin
                     units <= units - 3'd1;
                  end
               end else begin
                  presc <= presc + PW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
